// File: rtl/chan_scan_if.sv
// Channel-scan mux bus: packed channel inputs and controls in, one tagged registered sample out.
interface chan_scan_if #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic                  sel_load;
  logic                  hold;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  wrap;
  logic                  sel_err;

  modport master (
    output in_data, mode, sel, sel_load, hold,
    input  out_data, out_ch, out_valid, wrap, sel_err
  );

  modport slave (
    input  in_data, mode, sel, sel_load, hold,
    output out_data, out_ch, out_valid, wrap, sel_err
  );
endinterface

// File: rtl/chan_scan_mux.sv
// Registered N-channel mux with manual select and dwell-timed round-robin scan.
// Each lane masks its own data by a one-hot compare; lanes are OR-combined.
module chan_lane #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 3,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] cur_ch,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] masked
);
  assign masked = (cur_ch == SEL_W'(IDX)) ? data : '0;
endmodule

module chan_scan_mux #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 1,
  parameter int DWELL = 4
) (
  input logic       clk,
  input logic       rst_n,
  chan_scan_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(N_CH);

  logic [N_CH-1:0][WIDTH-1:0] lane_data, lane_masked;
  logic [WIDTH-1:0]           sel_data;

  logic [SEL_W-1:0] cur_ch, ch_nxt;
  logic [CNT_W-1:0] dwell_cnt, cnt_nxt;
  logic             mode_q;
  logic             wrap_nxt, err_nxt, sel_ok;

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_valid_q, wrap_q, sel_err_q;

  assign lane_data = bus.in_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    chan_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
      .cur_ch (cur_ch),
      .data   (lane_data[k]),
      .masked (lane_masked[k])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) sel_data |= lane_masked[k];
  end

  // Extra MSB lets non-power-of-2 channel counts reject out-of-range selects.
  assign sel_ok = {1'b0, bus.sel} < CH_LIMIT;

  always_comb begin
    ch_nxt   = cur_ch;
    cnt_nxt  = dwell_cnt;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (bus.sel_load) begin
      cnt_nxt = '0;
      if (sel_ok) ch_nxt = bus.sel;
      else        err_nxt = 1'b1;
    end else if (bus.mode && !mode_q) begin
      // Entering scan restarts the dwell so the current channel gets a full period.
      cnt_nxt = '0;
    end else if (bus.mode && !bus.hold) begin
      if (dwell_cnt == CNT_LAST) begin
        cnt_nxt = '0;
        if (cur_ch == CH_LAST) begin
          ch_nxt   = '0;
          wrap_nxt = 1'b1;
        end else begin
          ch_nxt = cur_ch + 1'b1;
        end
      end else begin
        cnt_nxt = dwell_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_ch      <= '0;
      dwell_cnt   <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      cur_ch      <= ch_nxt;
      dwell_cnt   <= cnt_nxt;
      mode_q      <= bus.mode;
      out_data_q  <= sel_data;
      out_ch_q    <= cur_ch;
      out_valid_q <= 1'b1;
      wrap_q      <= wrap_nxt;
      sel_err_q   <= err_nxt;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed + randomized checks of chan_scan_mux against a behavioural channel/dwell model.
module tb_chan_scan_mux;
  localparam int W  = 4;
  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst6_n = 1'b0;
  always #5 clk = ~clk;

  chan_scan_if #(.N_CH(8), .WIDTH(W)) bus8 ();
  chan_scan_if #(.N_CH(6), .WIDTH(W)) bus6 ();

  chan_scan_mux #(.N_CH(8), .WIDTH(W), .DWELL(DW)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );
  chan_scan_mux #(.N_CH(6), .WIDTH(W), .DWELL(DW)) dut6 (
    .clk(clk), .rst_n(rst6_n), .bus(bus6)
  );

  int vecs = 0;
  int errs = 0;

  // reference model: channel being shown next, cycles spent on it, last mode seen
  int m_ch = 0, m_cnt = 0;
  bit m_mode = 1'b0;
  logic [W-1:0] e_data = '0;
  int e_ch = 0;
  bit e_val = 1'b0, e_wrap = 1'b0, e_err = 1'b0;

  int scan_seq[10] = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
  int scan6_seq[8] = '{5, 5, 5, 5, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_ch = 0; m_cnt = 0; m_mode = 1'b0;
      e_data = '0; e_ch = 0; e_val = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
    end else begin
      e_data = bus8.in_data[m_ch*W +: W];
      e_ch   = m_ch;
      e_val  = 1'b1;
      e_wrap = 1'b0;
      e_err  = 1'b0;
      if (bus8.sel_load) begin
        m_cnt = 0;
        if (int'(bus8.sel) < 8) m_ch = int'(bus8.sel);
        else e_err = 1'b1;
      end else if (bus8.mode && !m_mode) begin
        m_cnt = 0;
      end else if (bus8.mode && !bus8.hold) begin
        m_cnt++;
        if (m_cnt == DW) begin
          m_cnt  = 0;
          m_ch   = (m_ch + 1) % 8;
          e_wrap = (m_ch == 0);
        end
      end
      m_mode = bus8.mode;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_data",  32'(bus8.out_data),  32'(e_data));
    chk("out_ch",    32'(bus8.out_ch),    32'(e_ch));
    chk("out_valid", 32'(bus8.out_valid), 32'(e_val));
    chk("wrap",      32'(bus8.wrap),      32'(e_wrap));
    chk("sel_err",   32'(bus8.sel_err),   32'(e_err));
  endtask

  task automatic step6();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_data"},  32'(bus8.out_data),  32'd0);
    chk({tag, "_ch"},    32'(bus8.out_ch),    32'd0);
    chk({tag, "_valid"}, 32'(bus8.out_valid), 32'd0);
    chk({tag, "_wrap"},  32'(bus8.wrap),      32'd0);
    chk({tag, "_err"},   32'(bus8.sel_err),   32'd0);
  endtask

  initial begin
    int n;
    int shown;
    bit bad6;
    bus8.in_data = '0; bus8.mode = 1'b0; bus8.sel = '0; bus8.sel_load = 1'b0; bus8.hold = 1'b0;
    bus6.in_data = '0; bus6.mode = 1'b0; bus6.sel = '0; bus6.sel_load = 1'b0; bus6.hold = 1'b0;

    // reset held for two edges under random inputs
    rst_n = 1'b0;
    repeat (2) begin
      bus8.in_data  = 32'($urandom);
      bus8.mode     = 1'($urandom);
      bus8.sel      = 3'($urandom);
      bus8.sel_load = 1'($urandom);
      bus8.hold     = 1'($urandom);
      step();
      chk_zero8("rst");
    end

    rst_n = 1'b1;
    bus8.mode = 1'b0; bus8.sel = '0; bus8.sel_load = 1'b0; bus8.hold = 1'b0;
    for (int k = 0; k < 8; k++) bus8.in_data[k*W +: W] = W'(k + 1);
    step();
    chk("first_valid", 32'(bus8.out_valid), 32'd1);
    chk("first_data",  32'(bus8.out_data),  32'h1);

    // manual select
    bus8.sel = 3'd5; bus8.sel_load = 1'b1;
    step();
    bus8.sel_load = 1'b0;
    step();
    chk("man_ch",   32'(bus8.out_ch),   32'd5);
    chk("man_data", 32'(bus8.out_data), 32'h6);
    repeat (4) begin
      step();
      chk("man_hold_ch", 32'(bus8.out_ch), 32'd5);
    end
    bus8.in_data[5*W +: W] = 4'hF;
    step();
    chk("man_newdata", 32'(bus8.out_data), 32'hF);
    bus8.in_data[5*W +: W] = 4'h6;
    step();

    // scan from channel 6 through the wrap
    bus8.sel = 3'd6; bus8.sel_load = 1'b1;
    step();
    bus8.sel_load = 1'b0;
    step();
    bus8.mode = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("scan_ch",   32'(bus8.out_ch), 32'(scan_seq[i]));
      chk("scan_wrap", 32'(bus8.wrap),   32'(i == 5));
    end

    // hold stretches channel 2's dwell
    n = 0;
    while (bus8.out_ch != 3'd2 && n < 24) begin step(); n++; end
    chk("hold_reach", 32'(bus8.out_ch), 32'd2);
    shown = 1;
    for (int i = 0; i < 20; i++) begin
      bus8.hold = (i < 4);
      step();
      if (bus8.out_ch != 3'd2) break;
      shown++;
    end
    bus8.hold = 1'b0;
    chk("hold_len",  32'(shown),        32'd7);
    chk("hold_next", 32'(bus8.out_ch),  32'd3);

    // load on the edge a scan advance would occur
    n = 0;
    while (bus8.out_ch != 3'd5 && n < 24) begin step(); n++; end
    chk("load_reach", 32'(bus8.out_ch), 32'd5);
    step();
    bus8.sel = 3'd4; bus8.sel_load = 1'b1;
    step();
    bus8.sel_load = 1'b0;
    chk("load_old", 32'(bus8.out_ch), 32'd5);
    repeat (3) begin
      step();
      chk("load_dwell", 32'(bus8.out_ch), 32'd4);
    end
    step();
    chk("load_after", 32'(bus8.out_ch), 32'd5);

    // reset in the middle of a scan
    step();
    rst_n = 1'b0;
    step();
    chk_zero8("midrst");
    rst_n = 1'b1;
    step();
    chk("midrst_valid", 32'(bus8.out_valid), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      bus8.mode     = ($urandom_range(9, 0) < 7);
      bus8.hold     = ($urandom_range(9, 0) < 2);
      bus8.sel_load = ($urandom_range(19, 0) == 0);
      bus8.sel      = 3'($urandom);
      if ($urandom_range(7, 0) == 0) bus8.in_data = 32'($urandom);
      rst_n = ($urandom_range(99, 0) != 0);
      step();
    end
    rst_n = 1'b1;

    // six-channel instance: invalid selects and wrap at channel 5
    for (int k = 0; k < 6; k++) bus6.in_data[k*W +: W] = W'(k + 1);
    rst6_n = 1'b0;
    step6();
    chk("r6_valid", 32'(bus6.out_valid), 32'd0);
    rst6_n = 1'b1;
    bus6.sel = 3'd2; bus6.sel_load = 1'b1;
    step6();
    bus6.sel_load = 1'b0;
    step6();
    chk("r6_ch",   32'(bus6.out_ch),   32'd2);
    chk("r6_data", 32'(bus6.out_data), 32'h3);
    bus6.sel = 3'd7; bus6.sel_load = 1'b1;
    step6();
    bus6.sel_load = 1'b0;
    chk("err7_pulse", 32'(bus6.sel_err), 32'd1);
    chk("err7_ch",    32'(bus6.out_ch),  32'd2);
    step6();
    chk("err7_clear", 32'(bus6.sel_err), 32'd0);
    chk("err7_hold",  32'(bus6.out_ch),  32'd2);
    bus6.sel = 3'd6; bus6.sel_load = 1'b1;
    step6();
    bus6.sel_load = 1'b0;
    chk("err6_pulse", 32'(bus6.sel_err), 32'd1);
    step6();
    chk("err6_ch",    32'(bus6.out_ch),  32'd2);
    bus6.sel = 3'd5; bus6.sel_load = 1'b1;
    step6();
    bus6.sel_load = 1'b0;
    step6();
    bus6.mode = 1'b1;
    bad6 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step6();
      chk("scan6_ch",   32'(bus6.out_ch), 32'(scan6_seq[i]));
      chk("scan6_wrap", 32'(bus6.wrap),   32'(i == 3));
    end
    for (int i = 0; i < 30; i++) begin
      step6();
      if (bus6.out_ch > 3'd5) bad6 = 1'b1;
    end
    chk("scan6_range", 32'(bad6), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised, registered N-channel, W-bit multiplexer with manual and automatic round-robin scan modes. It generalises the lab's 8-to-1 single-bit select mux:

- the select is held in an internal channel register;
- the selected channel's data and index are registered together;
- an optional dwell timer steps through channels autonomously.

It feeds display/LED and sampling logic that needs a stable, tagged view of one channel at a time.

## Interface
Parameters:
- N_CH, 8, number of input channels (2..64).
- WIDTH, 1, bits per channel.
- DWELL, 4, cycles each channel is held in scan mode (1..65535).
- SEL_W, $clog2(N_CH), channel index width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  N_CH*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH].
- mode  in  1  0 = manual select, 1 = auto scan.
- sel  in  SEL_W  channel to load.
- sel_load  in  1  strobe that loads sel into the channel register.
- hold  in  1  freezes scan advance; dwell counter holds its value.
- out_data  out  WIDTH  registered data of out_ch.
- out_ch  out  SEL_W  channel index that out_data was sampled from.
- out_valid  out  1  out_data/out_ch hold a real sample.
- wrap  out  1  one-cycle pulse when scan advances from N_CH-1 to 0.
- sel_err  out  1  one-cycle pulse when sel_load is applied with sel >= N_CH.

## Operation
- State consists of:
  - cur_ch, the channel register (SEL_W bits);
  - dwell_cnt, the dwell counter (width $clog2(DWELL+1));
  - the output registers.
- Reset (rst_n=0 at an edge) sets cur_ch=0, dwell_cnt=0, out_data=0, out_ch=0, out_valid=0, wrap=0 and sel_err=0. Reset overrides every other input, including mid-scan.
- Every cycle out of reset: out_data <= in_data channel cur_ch, out_ch <= cur_ch, out_valid <= 1.
- Channel update priority, highest first:
  1. sel_load=1 and sel<N_CH: cur_ch <= sel, dwell_cnt <= 0. This applies in both modes.
  2. sel_load=1 and sel>=N_CH: cur_ch unchanged, sel_err pulses, dwell_cnt <= 0.
  3. mode=1, hold=0, dwell_cnt==DWELL-1: cur_ch <= (cur_ch==N_CH-1) ? 0 : cur_ch+1, dwell_cnt <= 0. wrap pulses on the 0 transition.
  4. mode=1, hold=0, otherwise: dwell_cnt <= dwell_cnt+1.
  5. mode=0 or hold=1: cur_ch and dwell_cnt unchanged.
- A mode transition 0->1 clears dwell_cnt to 0. Scan then starts from the current cur_ch, which dwells a full DWELL cycles.
- DWELL=1 advances the channel every cycle.
- For non-power-of-2 N_CH, cur_ch never takes values >= N_CH.
- wrap and sel_err are registered and high for exactly one cycle per event.

## Timing
- Data latency: 1 cycle. A change on in_data of the current channel at edge t appears on out_data after edge t+1.
- Select latency: sel_load sampled at edge t sets cur_ch at t. out_ch and out_data reflect the new channel after edge t+1.
- Scan period: each channel is shown on out_ch for exactly DWELL consecutive cycles when hold=0. A full cycle through all channels takes N_CH*DWELL cycles.
- out_valid goes 1 on the first edge with rst_n=1 and stays 1 until the next reset.
- The wrap pulse coincides with the cycle cur_ch becomes 0, so it leads out_ch==0 by one cycle.
- hold asserted for k cycles stretches the current dwell by exactly k cycles.

## Test plan
Bench configuration: N_CH=8, WIDTH=4, DWELL=3, in_data channel k = k+1 (0x1..0x8).
- Reset: hold rst_n=0 for 2 edges with random inputs. Outputs must be out_data=0, out_ch=0, out_valid=0, wrap=0, sel_err=0. After the first edge with rst_n=1: out_valid=1, out_data=0x1.
- Manual select: mode=0, pulse sel_load with sel=5. Two edges later out_ch=5, out_data=0x6, and these values hold indefinitely with no further strobes. Changing channel 5's data to 0xF appears on out_data 1 edge later.
- Scan and wrap: mode=1 from cur_ch=6. out_ch must show 6,6,6,7,7,7,0,0,0,1. wrap is high exactly once, on the cycle before out_ch first shows 0.
- Hold: in scan, assert hold for 4 cycles mid-dwell on channel 2. Channel 2 is then shown for 3+4=7 cycles total, and the next channel is 3.
- Load during scan: mode=1, sel_load with sel=4 on the edge a normal advance would occur. out_ch goes to 4, not the next sequential channel, and dwells a full 3 cycles.
- Errors and mid-run reset:
  - sel_load with sel=9 is invalid for the 3-bit sel, so instead use N_CH=6 with sel=7. sel_err pulses 1 cycle and out_ch is unchanged.
  - Asserting rst_n=0 mid-scan returns all outputs to their reset values on that edge.
